if_fetch: RTL and testbench

Instruction-fetch front end that sits directly upstream of `pu_rom`. It owns the program counter and drives word addresses into `pu_rom`. It captures the returned 32-bit instruction words and hands them, tagged with their PC, to the decode stage over a valid/ready handshake. It absorbs decode back-pressure and branch/jump redirects without losing or duplicating instructions.

---
 rtl/if_pkg.sv | 29 ++
 rtl/if_fetch_chk.sv | 30 +++
 rtl/if_fifo.sv | 86 ++++++++
 rtl/if_fetch.sv | 160 ++++++++++++++++
 tb/tb_if_fetch.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//
// Contents:
//   IF_RESET_PC_DEF - default PC fetched after reset
//   IF_INST_NOP     - instruction word used for a misaligned-redirect marker entry
//   IF_PC_STEP      - byte increment between sequential instruction words
//   if_entry_t      - one instruction-buffer entry {pc, inst[, misalign]}
//   if_align_pc()   - forces a byte address onto a word boundary
//
// Optional feature macro: IF_FETCH_MISALIGN_EN adds the per-entry misalign flag.
package if_pkg;

    localparam logic [31:0] IF_RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] IF_INST_NOP     = 32'h0000_0013;
    localparam logic [31:0] IF_PC_STEP      = 32'h0000_0004;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
`ifdef IF_FETCH_MISALIGN_EN
        logic        misalign;
`endif
    } if_entry_t;

    function automatic logic [31:0] if_align_pc(input logic [31:0] raw);
        return {raw[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_chk.sv
// Property checker for the fetch front end's instruction buffer.
//
// Ports:
//   clk, rst - clock and synchronous active-high reset
//   push     - entry written into the buffer this cycle
//   pop      - head entry consumed this cycle
//   count    - current buffer occupancy
//
// The credit rule in if_fetch guarantees a free slot for every response, so a
// push into a full buffer without a matching pop would mean a lost instruction.
module if_fetch_chk #(
    parameter int DEPTH = 2,
    parameter int CW    = 2
) (
    input logic          clk,
    input logic          rst,
    input logic          push,
    input logic          pop,
    input logic [CW-1:0] count
);

    property p_no_overflow;
        @(posedge clk) disable iff (rst)
            !(push && (count == CW'(DEPTH)) && !pop);
    endproperty

    a_no_overflow: assert property (p_no_overflow)
        else $error("if_fetch: instruction buffer overflow");

endmodule

// File: rtl/if_fifo.sv
// Synchronous instruction buffer holding if_entry_t words.
//
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   push       - write push_data this cycle (ignored when full with no pop)
//   push_data  - entry to write
//   pop        - drop the head entry this cycle (ignored when empty)
//   flush      - empty the buffer; takes effect after any same-cycle push/pop
//   head       - current head entry (don't-care while valid is low)
//   valid      - buffer holds at least one entry
//   count      - number of entries held
//
// DEPTH must be a power of two so the pointers wrap naturally.
module if_fifo
    import if_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  if_entry_t     push_data,
    input  logic          pop,
    input  logic          flush,
    output if_entry_t     head,
    output logic          valid,
    output logic [CW-1:0] count
);

    localparam int AW = $clog2(DEPTH);

    if_entry_t     mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          empty_s;
    logic          full_s;
    logic          do_push_s;
    logic          do_pop_s;

    // Qualify push/pop against the current fill level.
    always_comb begin
        empty_s   = (count_r == {CW{1'b0}});
        full_s    = (count_r == CW'(DEPTH));
        do_pop_s  = pop & ~empty_s;
        do_push_s = push & (~full_s | do_pop_s);
    end

    // Entry storage; no reset needed since count_r gates visibility.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; flush overrides the same-cycle push/pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1'b1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1'b1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1'b1);
                2'b01:   count_r <= count_r - CW'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign valid = ~empty_s;
    assign count = count_r;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end feeding decode from pu_rom.
//
// Owns the program counter, issues word addresses to the ROM, buffers returned
// words tagged with their PC and presents them to decode over valid/ready.
// Redirects flush everything in flight and restart fetch at the target.
//
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   rom_addr_o        - byte address to pu_rom (always the current PC)
//   rom_data_i        - pu_rom word, valid one cycle after its address
//   redirect_valid_i  - one-cycle redirect pulse
//   redirect_pc_i     - redirect target
//   if_valid_o        - head instruction valid
//   if_ready_i        - decode accepts the head this cycle
//   if_inst_o         - head instruction word
//   if_pc_o           - PC of the head instruction
//   if_misalign_o     - head entry marks a misaligned redirect (macro only)
//
// Optional feature macro: IF_FETCH_MISALIGN_EN. When defined, a redirect to a
// non-word-aligned target queues a single NOP marker entry flagged misaligned
// and fetch stalls until the next redirect. When undefined, the low two target
// bits are dropped.
module if_fetch
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = IF_RESET_PC_DEF,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_data_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        if_valid_o,
    input  logic        if_ready_i,
    output logic [31:0] if_inst_o,
    output logic [31:0] if_pc_o
`ifdef IF_FETCH_MISALIGN_EN
    ,
    output logic        if_misalign_o
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]   pc_r;
    logic [31:0]   req_pc_r;
    logic          inflight_r;
    logic [CW-1:0] fifo_count_s;
    logic [CW-1:0] occ_s;
    logic          pop_s;
    logic          can_issue_s;
    logic          issue_s;
    logic          push_s;
    if_entry_t     push_entry_s;
    if_entry_t     head_s;

`ifdef IF_FETCH_MISALIGN_EN
    logic          stall_r;
    logic          mis_push_r;
    logic [31:0]   mis_pc_r;
`endif

    // Credit logic: an outstanding request already owns a buffer slot, so a new
    // one is issued only while a slot remains (or one frees up this cycle).
    always_comb begin
        pop_s       = if_valid_o & if_ready_i;
        occ_s       = fifo_count_s + {{(CW-1){1'b0}}, inflight_r};
        can_issue_s = (occ_s < CW'(FIFO_DEPTH)) |
                      ((occ_s == CW'(FIFO_DEPTH)) & pop_s);
`ifdef IF_FETCH_MISALIGN_EN
        issue_s = can_issue_s & ~redirect_valid_i & ~stall_r;
        push_s  = (inflight_r | mis_push_r) & ~redirect_valid_i;
        if (mis_push_r) begin
            push_entry_s.pc       = mis_pc_r;
            push_entry_s.inst     = IF_INST_NOP;
            push_entry_s.misalign = 1'b1;
        end else begin
            push_entry_s.pc       = req_pc_r;
            push_entry_s.inst     = rom_data_i;
            push_entry_s.misalign = 1'b0;
        end
`else
        issue_s           = can_issue_s & ~redirect_valid_i;
        push_s            = inflight_r & ~redirect_valid_i;
        push_entry_s.pc   = req_pc_r;
        push_entry_s.inst = rom_data_i;
`endif
    end

    // PC and outstanding-request tracking; redirect beats issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r       <= RESET_PC;
            req_pc_r   <= RESET_PC;
            inflight_r <= 1'b0;
        end else if (redirect_valid_i) begin
            pc_r       <= if_align_pc(redirect_pc_i);
            inflight_r <= 1'b0;
        end else if (issue_s) begin
            pc_r       <= pc_r + IF_PC_STEP;
            req_pc_r   <= pc_r;
            inflight_r <= 1'b1;
        end else begin
            inflight_r <= 1'b0;
        end
    end

`ifdef IF_FETCH_MISALIGN_EN
    // Misaligned redirect: the marker entry is queued the cycle after the flush
    // so the flush cannot swallow it; fetch stays stalled until a new redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_r    <= 1'b0;
            mis_push_r <= 1'b0;
            mis_pc_r   <= 32'h0000_0000;
        end else if (redirect_valid_i) begin
            stall_r    <= |redirect_pc_i[1:0];
            mis_push_r <= |redirect_pc_i[1:0];
            mis_pc_r   <= redirect_pc_i;
        end else begin
            mis_push_r <= 1'b0;
        end
    end
`endif

    if_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .flush     (redirect_valid_i),
        .head      (head_s),
        .valid     (if_valid_o),
        .count     (fifo_count_s)
    );

    if_fetch_chk #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .count (fifo_count_s)
    );

    assign rom_addr_o = pc_r;
    assign if_inst_o  = head_s.inst;
    assign if_pc_o    = head_s.pc;
`ifdef IF_FETCH_MISALIGN_EN
    assign if_misalign_o = head_s.misalign;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios followed by randomized
// ready/redirect/reset traffic, all checked against a stream-level model that
// expects consecutive word PCs from the last restart point.
module tb_if_fetch;
    import if_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i = 32'h0000_0000;
    logic        redirect_valid_i = 1'b0;
    logic [31:0] redirect_pc_i = 32'h0000_0000;
    logic        if_valid_o;
    logic        if_ready_i = 1'b0;
    logic [31:0] if_inst_o;
    logic [31:0] if_pc_o;
`ifdef IF_FETCH_MISALIGN_EN
    logic        if_misalign_o;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_pc   = RST_PC;
    logic        exp_mis  = 1'b0;
    logic        exp_dead = 1'b0;
    int          gap      = 0;
    logic [31:0] addr_prev;
    logic [31:0] frozen;

    always #5 clk = ~clk;

    if_fetch #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rom_addr_o       (rom_addr_o),
        .rom_data_i       (rom_data_i),
        .redirect_valid_i (redirect_valid_i),
        .redirect_pc_i    (redirect_pc_i),
        .if_valid_o       (if_valid_o),
        .if_ready_i       (if_ready_i),
        .if_inst_o        (if_inst_o),
        .if_pc_o          (if_pc_o)
`ifdef IF_FETCH_MISALIGN_EN
        ,
        .if_misalign_o    (if_misalign_o)
`endif
    );

    // ROM content: word i holds 32'h1000_0000 + i.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + {2'b00, a[31:2]};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h required %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs at the falling edge, score any handshake
    // against the model, then answer the address presented this cycle.
    task automatic step(input logic rdy, input logic rv, input logic [31:0] rpc, input logic rs);
        logic popped;
        @(negedge clk);
        if_ready_i       = rdy;
        redirect_valid_i = rv;
        redirect_pc_i    = rpc;
        rst              = rs;
        addr_prev        = rom_addr_o;
        popped           = 1'b0;
        if (!rs && !rv && if_valid_o && rdy) begin
            popped = 1'b1;
            check("pop_pc", if_pc_o, exp_pc);
            check("pop_after_stall", 32'(exp_dead), 32'd0);
`ifdef IF_FETCH_MISALIGN_EN
            check("pop_misalign", 32'(if_misalign_o), 32'(exp_mis));
            if (exp_mis) begin
                check("pop_nop", if_inst_o, IF_INST_NOP);
                exp_mis  = 1'b0;
                exp_dead = 1'b1;
            end else begin
                check("pop_inst", if_inst_o, rom_word(exp_pc));
                exp_pc = exp_pc + 32'd4;
            end
`else
            check("pop_inst", if_inst_o, rom_word(exp_pc));
            exp_pc = exp_pc + 32'd4;
`endif
        end
        if (rs) begin
            exp_pc   = RST_PC;
            exp_mis  = 1'b0;
            exp_dead = 1'b0;
        end else if (rv) begin
`ifdef IF_FETCH_MISALIGN_EN
            exp_mis  = (rpc[1:0] != 2'b00);
            exp_pc   = exp_mis ? rpc : {rpc[31:2], 2'b00};
`else
            exp_pc   = {rpc[31:2], 2'b00};
`endif
            exp_dead = 1'b0;
        end
        if (rs || rv || !rdy || popped || exp_dead) gap = 0;
        else gap++;
        check("stall_bound", 32'(gap > 4), 32'd0);
        @(posedge clk);
        #1;
        rom_data_i = rom_word(addr_prev);
    endtask

    initial begin
        logic [31:0] tgt;
        repeat (3) step(1'b1, 1'b0, 32'd0, 1'b1);
        check("rst_valid", 32'(if_valid_o), 32'd0);
        check("rst_addr", rom_addr_o, RST_PC);

        // Start-up latency and streaming.
        step(1'b1, 1'b0, 32'd0, 1'b0);
        check("c1_valid", 32'(if_valid_o), 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        check("c2_pc", if_pc_o, RST_PC);
        for (int i = 0; i < 2; i++) begin
            check("stream_valid", 32'(if_valid_o), 32'd1);
            step(1'b1, 1'b0, 32'd0, 1'b0);
        end

        // Back-pressure for five cycles: address must freeze once full.
        step(1'b0, 1'b0, 32'd0, 1'b0);
        frozen = rom_addr_o;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 32'd0, 1'b0);
            check("addr_frozen", rom_addr_o, frozen);
            check("bp_valid", 32'(if_valid_o), 32'd1);
        end
        repeat (4) step(1'b1, 1'b0, 32'd0, 1'b0);

        // Redirect while a response is arriving.
        step(1'b1, 1'b1, 32'h0000_0040, 1'b0);
        check("rd_n1_valid", 32'(if_valid_o), 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        check("rd_n2_valid", 32'(if_valid_o), 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        check("rd_n3_valid", 32'(if_valid_o), 32'd1);
        check("rd_n3_pc", if_pc_o, 32'h0000_0040);
        repeat (3) step(1'b1, 1'b0, 32'd0, 1'b0);

        // PC wrap-around.
        step(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        check("wrap_pc0", if_pc_o, 32'hFFFF_FFF8);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        check("wrap_pc1", if_pc_o, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        check("wrap_pc2", if_pc_o, 32'h0000_0000);
        check("wrap_inst2", if_inst_o, rom_word(32'h0000_0000));

        // Reset pulse while the buffer is full.
        repeat (4) step(1'b0, 1'b0, 32'd0, 1'b0);
        check("full_valid", 32'(if_valid_o), 32'd1);
        step(1'b0, 1'b0, 32'd0, 1'b1);
        check("rp_valid", 32'(if_valid_o), 32'd0);
        check("rp_addr", rom_addr_o, RST_PC);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        check("rp_c1_valid", 32'(if_valid_o), 32'd0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        check("rp_c2_valid", 32'(if_valid_o), 32'd1);
        check("rp_c2_pc", if_pc_o, RST_PC);
        repeat (3) step(1'b1, 1'b0, 32'd0, 1'b0);

`ifdef IF_FETCH_MISALIGN_EN
        // Misaligned redirect yields one marker entry then no fetch.
        step(1'b1, 1'b1, 32'h0000_0022, 1'b0);
        frozen = rom_addr_o;
        step(1'b1, 1'b0, 32'd0, 1'b0);
        check("mis_valid", 32'(if_valid_o), 32'd1);
        check("mis_flag", 32'(if_misalign_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 32'd0, 1'b0);
            check("mis_no_issue", rom_addr_o, frozen);
            check("mis_empty", 32'(if_valid_o), 32'd0);
        end
        step(1'b1, 1'b1, 32'h0000_0030, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        step(1'b1, 1'b0, 32'd0, 1'b0);
        check("mis_resume_pc", if_pc_o, 32'h0000_0030);
        repeat (2) step(1'b1, 1'b0, 32'd0, 1'b0);
`endif

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            logic rdy;
            logic rv;
            logic rs;
            rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 19) == 0);
            rs  = ($urandom_range(0, 199) == 0);
            tgt = $urandom();
`ifdef IF_FETCH_MISALIGN_EN
            tgt[1:0] = 2'b00;
`endif
            step(rdy, rv, tgt, rs);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
